// File: rtl/rgb_gray_seq.sv
// ============================================================================
// Module   : rgb_gray_seq
// Purpose  : Sequenced RGB-to-gray converter with one shared coefficient MAC
//            and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_gray_seq #(
  parameter int m = 8,
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [m-1:0] r,
  input  logic [m-1:0] g,
  input  logic [m-1:0] b,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] y,
  output logic         busy
);

  localparam int c_AW   = m + 9;
  localparam int c_S    = 8 + m - n;
  localparam int c_HALF = 1 << (c_S - 1);
  localparam int c_MAX  = (1 << n) - 1;

  localparam logic [7:0] c_KR_CIE  = 8'd54;
  localparam logic [7:0] c_KG_CIE  = 8'd184;
  localparam logic [7:0] c_KB_CIE  = 8'd18;
  localparam logic [7:0] c_KR_NTSC = 8'd77;
  localparam logic [7:0] c_KG_NTSC = 8'd150;
  localparam logic [7:0] c_KB_NTSC = 8'd29;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC_R = 3'd1,
    S_ACC_G = 3'd2,
    S_ACC_B = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            state_q;
  logic [c_AW-1:0]   acc_q;
  logic [m-1:0]      r_q, g_q, b_q;
  logic              mode_q;
  logic [n-1:0]      y_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [7:0]        coef_d;
  logic [m-1:0]      op_d;
  logic [c_AW-1:0]   prod_d;
  logic [c_AW-1:0]   sum_d;
  logic [c_AW-1:0]   rnd_d;
  logic [c_AW-1:0]   scaled_d;
  logic [n-1:0]      y_d;
  logic              accept_d;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
  assign accept_d  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

  // One multiplier: coefficient and operand are steered by the current state.
  always_comb begin
    coef_d = 8'd0;
    op_d   = '0;
    case (state_q)
      S_ACC_R: begin
        coef_d = mode_q ? c_KR_NTSC : c_KR_CIE;
        op_d   = r_q;
      end
      S_ACC_G: begin
        coef_d = mode_q ? c_KG_NTSC : c_KG_CIE;
        op_d   = g_q;
      end
      S_ACC_B: begin
        coef_d = mode_q ? c_KB_NTSC : c_KB_CIE;
        op_d   = b_q;
      end
      default: begin
        coef_d = 8'd0;
        op_d   = '0;
      end
    endcase
    prod_d   = c_AW'(coef_d) * c_AW'(op_d);
    sum_d    = acc_q + prod_d;
    rnd_d    = sum_d + c_AW'(c_HALF);
    scaled_d = rnd_d >> c_S;
    y_d      = (scaled_d > c_AW'(c_MAX)) ? {n{1'b1}} : scaled_d[n-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            r_q     <= r;
            g_q     <= g;
            b_q     <= b;
            mode_q  <= mode;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ACC_R;
          end
        end
        S_ACC_R: begin
          acc_q   <= sum_d;
          state_q <= S_ACC_G;
        end
        S_ACC_G: begin
          acc_q   <= sum_d;
          state_q <= S_ACC_B;
        end
        S_ACC_B: begin
          y_q         <= y_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          // Accepting the next pixel here is what gives 4-cycle throughput.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept_d) begin
              r_q     <= r;
              g_q     <= g;
              b_q     <= b;
              mode_q  <= mode;
              acc_q   <= '0;
              state_q <= S_ACC_R;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_gray_seq.sv
// ============================================================================
// Module   : tb_rgb_gray_seq
// Purpose  : Scoreboard bench for rgb_gray_seq, 8-bit and 4-bit outputs in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_gray_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
  logic       force_ready = 1'b1;
  logic       rnd_en = 1'b0;
  logic       rnd_bit = 1'b0;
  logic       out_ready;

  logic       in_ready8, in_ready4, out_valid8, out_valid4, busy8, busy4;
  logic [7:0] y8;
  logic [3:0] y4;

  int  checks = 0;
  int  errors = 0;
  int  q8[$];
  int  q4[$];
  int  me8, me4;
  bit  stream_on = 1'b0;
  time last_t = 0;

  assign out_ready = rnd_en ? rnd_bit : force_ready;

  rgb_gray_seq #(.m(8), .n(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .r(r), .g(g), .b(b), .mode(mode), .out_valid(out_valid8),
    .out_ready(out_ready), .y(y8), .busy(busy8)
  );

  rgb_gray_seq #(.m(8), .n(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .r(r), .g(g), .b(b), .mode(mode), .out_valid(out_valid4),
    .out_ready(out_ready), .y(y4), .busy(busy4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_y(input int rr, input int gg, input int bb, input int md, input int nn);
    int kr, kg, kb, s, sh, v;
    if (md != 0) begin kr = 77; kg = 150; kb = 29; end
    else         begin kr = 54; kg = 184; kb = 18; end
    s  = kr * rr + kg * gg + kb * bb;
    sh = 16 - nn;
    v  = (s + (1 << (sh - 1))) / (1 << sh);
    if (v > (1 << nn) - 1) v = (1 << nn) - 1;
    return v;
  endfunction

  // Presents a pixel and returns just after the edge that accepted it.
  task automatic send(input int rr, input int gg, input int bb, input int md,
                      input int e8, input int e4);
    bit ok = 1'b0;
    @(negedge clk);
    r = 8'(rr); g = 8'(gg); b = 8'(bb); mode = 1'(md); in_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      #1;
      if (in_ready8) begin
        ok = 1'b1;
        q8.push_back(e8);
        q4.push_back(e4);
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
    end
    #1;
    in_valid = 1'b0;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
  endtask

  task automatic sendr();
    int rr, gg, bb, md;
    rr = int'($urandom_range(0, 255));
    gg = int'($urandom_range(0, 255));
    bb = int'($urandom_range(0, 255));
    md = int'($urandom_range(0, 1));
    send(rr, gg, bb, md, ref_y(rr, gg, bb, md, 8), ref_y(rr, gg, bb, md, 4));
  endtask

  task automatic lat_check();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #2;
      chk("latency_out_valid", 32'(out_valid8), (k == 4) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q8.size() != 0; k++) @(negedge clk);
    if (q8.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q8.size());
    end
  endtask

  // Monitor: pops an expectation on every output handshake.
  always begin
    @(negedge clk); #2;
    if (!rst && out_valid8 && out_ready) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got y=%0d expected no output", y8);
      end else begin
        me8 = q8.pop_front();
        me4 = q4.pop_front();
        chk("y_n8", 32'(y8), 32'(me8));
        chk("y_n4", 32'(y4), 32'(me4));
        chk("out_valid_n4", 32'(out_valid4), 32'd1);
        if (stream_on && last_t != 0) chk("stream_interval", 32'($time - last_t), 32'd40);
        last_t = $time;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_y", 32'(y8), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready8), 32'd1);

    send(255, 0, 0, 1, 77, 5);   lat_check();
    send(0, 255, 0, 1, 149, 9);  lat_check();
    send(0, 0, 255, 1, 29, 2);
    send(0, 0, 0, 0, 0, 0);
    send(55, 55, 55, 0, 55, 3);
    send(255, 255, 255, 0, 255, 15);
    send(255, 0, 0, 0, 54, 3);
    send(255, 255, 255, 1, 255, 15);
    drain();

    last_t = 0;
    stream_on = 1'b1;
    repeat (6) sendr();
    drain();
    stream_on = 1'b0;

    // Output stall with a competing pixel waiting at the input.
    force_ready = 1'b0;
    send(255, 255, 255, 1, 255, 15);
    for (int k = 0; k < 50 && !out_valid8; k++) begin @(negedge clk); #2; end
    r = 8'd10; g = 8'd200; b = 8'd30; mode = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #2;
      chk("stall_out_valid", 32'(out_valid8), 32'd1);
      chk("stall_y", 32'(y8), 32'd255);
      chk("stall_in_ready", 32'(in_ready8), 32'd0);
    end
    @(negedge clk);
    force_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready8), 32'd1);
    q8.push_back(ref_y(10, 200, 30, 0, 8));
    q4.push_back(ref_y(10, 200, 30, 0, 4));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Abort a conversion in ACC_G.
    send(255, 255, 255, 0, 255, 15);
    drain();
    send(100, 50, 25, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid8), 32'd0);
    chk("abort_y", 32'(y8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    q8.delete();
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_abort_in_ready", 32'(in_ready8), 32'd1);
    send(255, 0, 0, 1, 77, 5);
    lat_check();
    sendr();
    drain();

    rnd_en = 1'b1;
    repeat (40) begin
      sendr();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    rnd_en = 1'b0;
    drain();
    chk("queue_empty", 32'(q8.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
